alu_serial_seq: RTL and testbench

- Bit-serial sequencer that drives a single external 1-bit ALU slice across all WIDTH bit positions to execute one full-width MIPS ALU operation.
- Owns the slice's control/operand/carry side of the interface and collects its Result/CarryOut bits.
- Sits between the multicycle datapath control and one ALU slice instance.
- Trades area for latency: one operation takes WIDTH+1 cycles and uses a start/done handshake.

---
 rtl/alu_serial_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_serial_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks one external 1-bit MIPS ALU slice across
// WIDTH bit positions, LSB first, to build one full-width result.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             err,
  output logic [3:0]       slice_op,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; busy is high while bits are
  // being processed; done pulses for one cycle when result/zero/overflow/err
  // are valid, and they hold until the next accepted start.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  function automatic logic ctl_legal(input logic [3:0] c);
    return (c == CTL_AND) || (c == CTL_OR) || (c == CTL_ADD) ||
           (c == CTL_SUB) || (c == CTL_SLT) || (c == CTL_NOR);
  endfunction

  function automatic logic ctl_arith(input logic [3:0] c);
    return (c == CTL_ADD) || (c == CTL_SUB) || (c == CTL_SLT);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] fin_res;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    fin_res  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          ovf_d = 1'b0;
          if (ctl_legal(alu_ctl)) begin
            a_d     = op_a;
            b_d     = op_b;
            ctl_d   = alu_ctl;
            // Binvert doubles as the bit-0 carry so SUB/SLT form A + ~B + 1.
            carry_d = alu_ctl[2];
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            result_d = '0;
            err_d    = 1'b1;
            zero_d   = 1'b1;
            state_d  = S_FINISH;
          end
        end
      end

      S_RUN: begin
        // The accumulator fills from the top so bit k lands at index k after
        // WIDTH shifts; the visible result only changes on the final bit.
        acc_d   = {slice_result, acc_q[WIDTH-1:1]};
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          ovf_d   = ctl_arith(ctl_q) ? (carry_q ^ slice_cout) : 1'b0;
          fin_res = acc_d;
          if (ctl_q == CTL_SLT) begin
            fin_res = {{(WIDTH-1){1'b0}}, slice_result ^ ovf_d};
          end
          result_d = fin_res;
          zero_d   = (fin_res == '0);
          cnt_d    = '0;
          state_d  = S_FINISH;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // The slice has no "less" input wired, so SLT runs as a plain subtract and
  // the sign correction is applied after the last bit.
  always_comb begin
    slice_op  = 4'b0000;
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    if (state_q == S_RUN) begin
      slice_op  = (ctl_q == CTL_SLT) ? CTL_SUB : ctl_q;
      slice_a   = a_q[cnt_q];
      slice_b   = b_q[cnt_q];
      slice_cin = carry_q;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_FINISH);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq; a behavioural 1-bit MIPS ALU slice
// closes the loop on the slice_* interface.
module tb_alu_serial_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   alu_ctl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         err;
  logic [3:0]   slice_op;
  logic         slice_a;
  logic         slice_b;
  logic         slice_cin;
  logic         slice_result;
  logic         slice_cout;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .alu_ctl      (alu_ctl),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .zero         (zero),
    .overflow     (overflow),
    .err          (err),
    .slice_op     (slice_op),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_cin    (slice_cin),
    .slice_result (slice_result),
    .slice_cout   (slice_cout),
    .dbg_state    (dbg_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU slice: {Ainvert, Binvert, Operation[1:0]}
  logic sa, sb;
  always_comb begin
    sa = slice_op[3] ? ~slice_a : slice_a;
    sb = slice_op[2] ? ~slice_b : slice_b;
    case (slice_op[1:0])
      2'b00:   slice_result = sa & sb;
      2'b01:   slice_result = sa | sb;
      2'b10:   slice_result = sa ^ sb ^ slice_cin;
      default: slice_result = 1'b0;
    endcase
    slice_cout = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present one request, then wait (bounded) for done.
  // lat = edges after the start edge until done is seen; busy_n = cycles busy.
  task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n, output logic done_seen,
                        output logic done_after);
    start   = 1'b1;
    alu_ctl = ctl;
    op_a    = a;
    op_b    = b;
    @(posedge clk); #1;
    start   = 1'b0;
    op_a    = $urandom();
    op_b    = $urandom();
    lat     = 0;
    busy_n  = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    done_seen = done;
    @(posedge clk); #1;
    done_after = done;
  endtask

  int       lat, busy_n, done_cnt;
  logic     dseen, dafter;
  logic [W-1:0] exp_q[$];

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    alu_ctl = 4'b0000;
    op_a    = '0;
    op_b    = '0;
    #12;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, '0);
    check("rst_flags", W'({err, zero, overflow}), W'(0));
    check("rst_slice", W'({slice_op, slice_a, slice_b, slice_cin}), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with signed overflow, plus timing
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, lat, busy_n, dseen, dafter);
    check("add_done", W'(dseen), W'(1));
    check("add_latency", W'(lat), W'(W));
    check("add_busy_cycles", W'(busy_n), W'(W));
    check("add_done_pulse", W'(dafter), W'(0));
    check("add_result", result, 32'h8000_0000);
    check("add_ovf", W'(overflow), W'(1));
    check("add_zero", W'(zero), W'(0));
    check("idle_slice", W'({slice_op, slice_a, slice_b, slice_cin}), W'(0));

    // SUB equal operands
    run_op(4'b0110, 32'h5, 32'h5, lat, busy_n, dseen, dafter);
    check("sub0_done", W'(dseen), W'(1));
    check("sub0_result", result, '0);
    check("sub0_zero", W'(zero), W'(1));
    check("sub0_ovf", W'(overflow), W'(0));

    // SLT negative < positive
    run_op(4'b0111, 32'hFFFF_FFFD, 32'h2, lat, busy_n, dseen, dafter);
    check("slt1_result", result, 32'h1);
    check("slt1_ovf", W'(overflow), W'(0));
    check("slt1_zero", W'(zero), W'(0));

    // SLT with subtract overflow
    run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, lat, busy_n, dseen, dafter);
    check("slt2_result", result, 32'h0);
    check("slt2_ovf", W'(overflow), W'(1));
    check("slt2_zero", W'(zero), W'(1));

    // Logic ops
    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, busy_n, dseen, dafter);
    check("and_result", result, 32'hF000_F000);
    check("and_ovf", W'(overflow), W'(0));
    run_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, busy_n, dseen, dafter);
    check("or_result", result, 32'hFFF0_FFF0);
    check("or_ovf", W'(overflow), W'(0));
    run_op(4'b1100, 32'h0, 32'h0, lat, busy_n, dseen, dafter);
    check("nor_result", result, 32'hFFFF_FFFF);
    check("nor_ovf", W'(overflow), W'(0));
    check("nor_zero", W'(zero), W'(0));

    // start hammered during RUN/FINISH: ignored, single done
    exp_q.push_back(32'd30);
    start = 1'b1; alu_ctl = 4'b0010; op_a = 32'd10; op_b = 32'd20;
    @(posedge clk); #1;
    done_cnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) done_cnt++;
      start   = (i <= W);
      alu_ctl = 4'b0110;
      op_a    = $urandom();
      op_b    = $urandom();
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignore_done_count", W'(done_cnt), W'(1));
    check("ignore_result", result, exp_q.pop_front());

    // Illegal control code
    run_op(4'b0011, 32'h1234, 32'h5678, lat, busy_n, dseen, dafter);
    check("ill_done", W'(dseen), W'(1));
    check("ill_latency", W'(lat), W'(0));
    check("ill_busy", W'(busy_n), W'(0));
    check("ill_err", W'(err), W'(1));
    check("ill_result", result, '0);
    check("ill_zero", W'(zero), W'(1));
    check("ill_ovf", W'(overflow), W'(0));

    // SUB with overflow; also clears err
    run_op(4'b0110, 32'h8000_0000, 32'h1, lat, busy_n, dseen, dafter);
    check("sub1_result", result, 32'h7FFF_FFFF);
    check("sub1_ovf", W'(overflow), W'(1));
    check("sub1_err_clr", W'(err), W'(0));

    // Reset in the middle of an ADD (bit 10)
    start = 1'b1; alu_ctl = 4'b0010; op_a = 32'h1111_1111; op_b = 32'h2222_2222;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("pre_rst_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_result", result, '0);
    check("mid_rst_flags", W'({done, err, zero, overflow}), W'(0));
    check("mid_rst_slice", W'({slice_op, slice_a, slice_b, slice_cin}), W'(0));
    done_cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (done) done_cnt++; end
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done) done_cnt++; end
    check("mid_rst_no_done", W'(done_cnt), W'(0));

    run_op(4'b0010, 32'd3, 32'd4, lat, busy_n, dseen, dafter);
    check("post_rst_done", W'(dseen), W'(1));
    check("post_rst_result", result, 32'd7);
    check("post_rst_zero", W'(zero), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
